// File: rtl/moka_rv32i_trace_pkg.sv
// Shared types for the commit tracer: the record layout pushed through the
// trace FIFO, plus small helpers used when building a record.
package moka_rv32i_trace_pkg;

    localparam int TRACE_SEQ_W  = 32;
    localparam int TRACE_DATA_W = 32;

    localparam logic [4:0] X0 = 5'd0;

    typedef struct packed {
        logic [TRACE_SEQ_W-1:0]  seq;
        logic [TRACE_DATA_W-1:0] pc;
        logic [TRACE_DATA_W-1:0] instr;
        logic                    rd_we;
        logic [4:0]              rd;
        logic [TRACE_DATA_W-1:0] rd_data;
        logic                    mem_we;
        logic [TRACE_DATA_W-1:0] mem_addr;
        logic [TRACE_DATA_W-1:0] mem_wdata;
        logic [TRACE_DATA_W-1:0] next_pc;
    } trace_rec_t;

    localparam int TRACE_REC_W = $bits(trace_rec_t);

    // Sequential successor unless the branch/jump was taken; wraps modulo 2^W.
    function automatic logic [TRACE_DATA_W-1:0] calc_next_pc(
        input logic [TRACE_DATA_W-1:0] pc,
        input logic                    taken,
        input logic [TRACE_DATA_W-1:0] target
    );
        return taken ? target : (pc + TRACE_DATA_W'(4));
    endfunction

endpackage

// File: rtl/moka_rv32i_sc_commit_tracer_fifo.sv
// Generic first-word-fall-through FIFO. The head entry is presented on rdata
// combinationally; a push into a full FIFO is accepted only when a pop
// happens at the same edge. Pop while empty is ignored.
module moka_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    // Qualify requests and compute next pointer/occupancy values.
    always_comb begin
        do_pop   = pop & (level_q != '0);
        do_push  = push & ((level_q != LW'(DEPTH)) | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: entries are only visible once level covers them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

endmodule

// File: rtl/moka_rv32i_sc_commit_tracer.sv
// Commit tracer for the single-cycle core. Builds one record per retired
// instruction, queues it in an FWFT FIFO and streams it over valid/ready.
// Sequence numbering counts every capture attempt, so dropped records show up
// as gaps; drop count and sticky overflow let the sink detect the loss.
module moka_rv32i_sc_commit_tracer
    import moka_rv32i_trace_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_en,
    input  logic                     retire,
    input  logic [DATA_WIDTH-1:0]    pc,
    input  logic [DATA_WIDTH-1:0]    instruction,
    input  logic                     RegWrite,
    input  logic [4:0]               rd,
    input  logic [DATA_WIDTH-1:0]    WD3,
    input  logic                     MemWrite,
    input  logic [DATA_WIDTH-1:0]    ALUResult,
    input  logic [DATA_WIDTH-1:0]    RD2,
    input  logic                     PCSrc,
    input  logic [DATA_WIDTH-1:0]    PCTarget,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [31:0]              trace_seq,
    output logic [DATA_WIDTH-1:0]    trace_pc,
    output logic [DATA_WIDTH-1:0]    trace_instr,
    output logic [DATA_WIDTH-1:0]    trace_next_pc,
    output logic                     trace_rd_we,
    output logic [4:0]               trace_rd,
    output logic [DATA_WIDTH-1:0]    trace_rd_data,
    output logic                     trace_mem_we,
    output logic [DATA_WIDTH-1:0]    trace_mem_addr,
    output logic [DATA_WIDTH-1:0]    trace_mem_wdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_WIDTH-1:0]     drop_cnt
);

    // The record struct is laid out for the package data width.
    if (DATA_WIDTH != TRACE_DATA_W) begin : g_bad_width
        $error("DATA_WIDTH must equal TRACE_DATA_W");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end

    logic [TRACE_SEQ_W-1:0] seq_q, seq_d;
    logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
    logic                   overflow_q, overflow_d;

    logic                   push_req, fifo_push, fifo_pop, drop;
    logic                   fifo_full, fifo_empty;
    logic [TRACE_REC_W-1:0] fifo_rdata;
    trace_rec_t             new_rec, head_rec;

    // Build the incoming record; fields that do not apply are zeroed so the
    // sink can compare records without masking.
    always_comb begin
        new_rec           = '0;
        new_rec.seq       = seq_q;
        new_rec.pc        = pc;
        new_rec.instr     = instruction;
        new_rec.rd_we     = RegWrite & (rd != X0);
        new_rec.rd        = rd;
        new_rec.rd_data   = new_rec.rd_we ? WD3 : '0;
        new_rec.mem_we    = MemWrite;
        new_rec.mem_addr  = MemWrite ? ALUResult : '0;
        new_rec.mem_wdata = MemWrite ? RD2 : '0;
        new_rec.next_pc   = calc_next_pc(pc, PCSrc, PCTarget);
    end

    // Handshake, drop detection and next-state for sequence/drop tracking.
    always_comb begin
        push_req   = retire & trace_en;
        fifo_pop   = trace_ready & ~fifo_empty;
        fifo_push  = push_req & (~fifo_full | fifo_pop);
        drop       = push_req & fifo_full & ~fifo_pop;
        seq_d      = push_req ? (seq_q + TRACE_SEQ_W'(1)) : seq_q;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
        end
        overflow_d = overflow_q | drop;
    end

    // Sequence, drop counter and sticky overflow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q      <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            seq_q      <= seq_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    moka_sync_fifo #(
        .WIDTH (TRACE_REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (new_rec),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // Head record, blanked while empty so stale storage never leaks out.
    always_comb begin
        head_rec = fifo_empty ? '0 : trace_rec_t'(fifo_rdata);
    end

    assign trace_valid     = ~fifo_empty;
    assign trace_seq       = head_rec.seq;
    assign trace_pc        = head_rec.pc;
    assign trace_instr     = head_rec.instr;
    assign trace_next_pc   = head_rec.next_pc;
    assign trace_rd_we     = head_rec.rd_we;
    assign trace_rd        = head_rec.rd;
    assign trace_rd_data   = head_rec.rd_data;
    assign trace_mem_we    = head_rec.mem_we;
    assign trace_mem_addr  = head_rec.mem_addr;
    assign trace_mem_wdata = head_rec.mem_wdata;
    assign overflow        = overflow_q;
    assign drop_cnt        = drop_cnt_q;

endmodule
